// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 command sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    StOff,
    StPwrup,
    StInitLoad,
    StSetup,
    StEnHi,
    StHold,
    StWait,
    StReady
  } lcd_state_e;

  // HD44780 instruction bytes used by the init ROM.
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] WAKE_8BIT    = 8'h30;
  localparam logic [7:0] FUNC_8BIT_2L = 8'h38;

  localparam int unsigned INIT_LEN = 7;

  // Three wake-up bytes, then function set, display on, clear, entry mode.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    WAKE_8BIT, WAKE_8BIT, WAKE_8BIT, FUNC_8BIT_2L, DISP_ON, CLEAR, ENTRY_INC
  };

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; expires on the last cycle of a loaded interval.
module lcd_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic [Width-1:0] o_value,
  output logic             o_expired
);

  logic [Width-1:0] r_cnt;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_value   = r_cnt;
  assign o_expired = (r_cnt == Width'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 bus sequencer: power-up, init ROM playback, then CPU bytes over valid/ready.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC   = 750000,
  parameter int unsigned WAKE_CYC    = 205000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 2500,
  parameter int unsigned CLR_CYC     = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] DATA,
  output logic       RS,
  output logic       RW,
  output logic       EN,
  output logic       ON
);

  localparam int unsigned MaxCyc = max_u(max_u(max_u(PWRUP_CYC, WAKE_CYC),
                                               max_u(SETUP_CYC, EN_HIGH_CYC)),
                                         max_u(max_u(HOLD_CYC, EXEC_CYC), CLR_CYC));
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  if (PWRUP_CYC == 0 || WAKE_CYC == 0 || SETUP_CYC == 0 || EN_HIGH_CYC == 0 ||
      HOLD_CYC == 0 || EXEC_CYC == 0 || CLR_CYC == 0) begin : g_bad_cycle_param
    $fatal(1, "lcd_cmd_sequencer: all cycle-count parameters must be nonzero");
  end

  lcd_state_e      r_state, w_state_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [7:0]      r_data, w_data_d;
  logic            r_rs, w_rs_d;
  logic            r_en, w_en_d;
  logic            r_on, w_on_d;
  logic            r_init_done, w_init_done_d;

  logic            w_load;
  logic [CntW-1:0] w_load_val;
  logic [CntW-1:0] w_wait_val;
  logic [CntW-1:0] w_cnt_value;
  logic            w_expired;

  lcd_timer #(
    .Width (CntW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_value    (w_cnt_value),
    .o_expired  (w_expired)
  );

  // Post-strobe wait for the byte currently on the bus; only the first init byte uses WAKE.
  always_comb begin
    if (!r_init_done && (r_idx == 3'd0)) begin
      w_wait_val = CntW'(WAKE_CYC);
    end else if (is_slow_cmd(r_rs, r_data)) begin
      w_wait_val = CntW'(CLR_CYC);
    end else begin
      w_wait_val = CntW'(EXEC_CYC);
    end
  end

  // Next-state logic; the timer is reloaded on entry to every state.
  always_comb begin
    w_state_d      = r_state;
    w_idx_d        = r_idx;
    w_data_d       = r_data;
    w_rs_d         = r_rs;
    w_on_d         = r_on;
    w_init_done_d  = r_init_done;
    w_load         = 1'b0;
    w_load_val     = '0;

    unique case (r_state)
      StOff: begin
        if (start) begin
          w_state_d  = StPwrup;
          w_on_d     = 1'b1;
          w_load     = 1'b1;
          w_load_val = CntW'(PWRUP_CYC);
        end
      end
      StPwrup: begin
        if (w_expired) begin
          w_state_d = StInitLoad;
          w_idx_d   = 3'd0;
          w_load    = 1'b1;
        end
      end
      StInitLoad: begin
        w_state_d  = StSetup;
        w_data_d   = INIT_ROM[r_idx];
        w_rs_d     = 1'b0;
        w_load     = 1'b1;
        w_load_val = CntW'(SETUP_CYC);
      end
      StSetup: begin
        if (w_expired) begin
          w_state_d  = StEnHi;
          w_load     = 1'b1;
          w_load_val = CntW'(EN_HIGH_CYC);
        end
      end
      StEnHi: begin
        if (w_expired) begin
          w_state_d  = StHold;
          w_load     = 1'b1;
          w_load_val = CntW'(HOLD_CYC);
        end
      end
      StHold: begin
        if (w_expired) begin
          w_state_d  = StWait;
          w_load     = 1'b1;
          w_load_val = w_wait_val;
        end
      end
      StWait: begin
        if (w_expired) begin
          w_load = 1'b1;
          if (!r_init_done && (r_idx < 3'(INIT_LEN - 1))) begin
            w_state_d = StInitLoad;
            w_idx_d   = r_idx + 3'd1;
          end else begin
            w_state_d     = StReady;
            w_init_done_d = 1'b1;
          end
        end
      end
      StReady: begin
        if (cmd_valid) begin
          w_state_d  = StSetup;
          w_data_d   = cmd_data;
          w_rs_d     = cmd_rs;
          w_load     = 1'b1;
          w_load_val = CntW'(SETUP_CYC);
        end
      end
      default: begin
        w_state_d = StOff;
      end
    endcase
  end

  // EN follows the next state so it is a clean register output, high only in StEnHi.
  assign w_en_d = (w_state_d == StEnHi);

  // State and bus output registers; reset drops the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StOff;
      r_idx       <= 3'd0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_data      <= w_data_d;
      r_rs        <= w_rs_d;
      r_en        <= w_en_d;
      r_on        <= w_on_d;
      r_init_done <= w_init_done_d;
    end
  end

  assign cmd_ready = (r_state == StReady);
  assign busy      = (r_state != StOff) && (r_state != StReady);
  assign init_done = r_init_done;
  assign DATA      = r_data;
  assign RS        = r_rs;
  assign RW        = 1'b0;
  assign EN        = r_en;
  assign ON        = r_on;

  logic w_unused_cnt;
  assign w_unused_cnt = ^w_cnt_value;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench: cycle-accurate expected trace built from phase durations.
module tb_lcd_cmd_sequencer;

  localparam int P_PWRUP = 20;
  localparam int P_WAKE  = 15;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 10;
  localparam int P_CLR   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, busy, RS, RW, EN, ON;
  logic [7:0] DATA;

  always #5 clk = ~clk;

  lcd_cmd_sequencer #(
    .PWRUP_CYC   (P_PWRUP),
    .WAKE_CYC    (P_WAKE),
    .SETUP_CYC   (P_SETUP),
    .EN_HIGH_CYC (P_EN),
    .HOLD_CYC    (P_HOLD),
    .EXEC_CYC    (P_EXEC),
    .CLR_CYC     (P_CLR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .init_done (init_done),
    .busy      (busy),
    .DATA      (DATA),
    .RS        (RS),
    .RW        (RW),
    .EN        (EN),
    .ON        (ON)
  );

  typedef struct packed {
    logic       rw;
    logic       on;
    logic       en;
    logic [7:0] data;
    logic       rs;
    logic       ready;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  logic [7:0] rom [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};

  obs_t       q[$];
  obs_t       exp_cur;
  logic       m_on, m_done, m_rs;
  logic [7:0] m_data;
  logic       last_acc;
  logic       prev_en;
  logic [8:0] en_log[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o = {RW, ON, EN, DATA, RS, cmd_ready, busy, init_done};
    return o;
  endfunction

  function automatic obs_t idle_rec();
    obs_t r;
    r.rw = 1'b0; r.on = m_on; r.en = 1'b0; r.data = m_data; r.rs = m_rs;
    r.ready = m_done; r.busy = 1'b0; r.done = m_done;
    return r;
  endfunction

  // Clear/home (instruction 0x01..0x03) gets the long wait; first wake byte gets WAKE.
  function automatic int exp_wait(input logic first_init, input logic rs, input logic [7:0] d);
    if (first_init) return P_WAKE;
    if (!rs && d >= 8'd1 && d <= 8'd3) return P_CLR;
    return P_EXEC;
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] d, input int w, input logic done);
    obs_t r;
    r.rw = 1'b0; r.on = 1'b1; r.en = 1'b0; r.data = d; r.rs = rs;
    r.ready = 1'b0; r.busy = 1'b1; r.done = done;
    repeat (P_SETUP) q.push_back(r);
    r.en = 1'b1;
    repeat (P_EN) q.push_back(r);
    r.en = 1'b0;
    repeat (P_HOLD + w) q.push_back(r);
    m_data = d;
    m_rs   = rs;
  endtask

  task automatic push_init();
    obs_t r;
    logic [7:0] prev;
    r.rw = 1'b0; r.on = 1'b1; r.en = 1'b0; r.data = 8'h00; r.rs = 1'b0;
    r.ready = 1'b0; r.busy = 1'b1; r.done = 1'b0;
    repeat (P_PWRUP) q.push_back(r);
    prev = 8'h00;
    for (int i = 0; i < 7; i++) begin
      r.data = prev;
      q.push_back(r);  // one load cycle, bus still shows the previous byte
      push_byte(1'b0, rom[i], exp_wait(i == 0, 1'b0, rom[i]), 1'b0);
      prev = rom[i];
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_on = 1'b0; m_done = 1'b0; m_data = 8'h00; m_rs = 1'b0;
    exp_cur = idle_rec();
    prev_en = 1'b0;
    en_log.delete();
  endtask

  // One clock: advance the model with the driven inputs, then compare every output.
  task automatic tick();
    obs_t nxt;
    last_acc = 1'b0;
    if (!m_on) begin
      if (start) begin
        m_on = 1'b1;
        push_init();
      end
    end else if (exp_cur.ready && cmd_valid) begin
      last_acc = 1'b1;
      push_byte(cmd_rs, cmd_data, exp_wait(1'b0, cmd_rs, cmd_data), 1'b1);
    end
    if (q.size() > 0) begin
      nxt = q.pop_front();
    end else begin
      if (m_on) m_done = 1'b1;
      nxt = idle_rec();
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_cur = nxt;
    check("trace{rw,on,en,data,rs,ready,busy,done}", 32'(dut_obs()), 32'(nxt));
    if (EN && !prev_en) en_log.push_back({RS, DATA});
    prev_en = EN;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("reset_async_en_on_data", {22'd0, EN, ON, DATA}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int g;
    cmd_rs = rs; cmd_data = d; cmd_valid = 1'b1;
    g = 0;
    do begin
      tick();
      g++;
    end while (!last_acc && g < 300);
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_init();
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("on_after_start", {31'd0, ON}, 32'd1);
    c = 1;
    while (!EN && c < 200) begin
      tick();
      c++;
    end
    check("start_to_first_en", c, 1 + P_PWRUP + 1 + P_SETUP);
    start = 1'b1;  // must be ignored while busy
    repeat (5) tick();
    start = 1'b0;
    c = 0;
    while (!init_done && c < 1000) begin
      tick();
      c++;
    end
    check("init_done_reached", {31'd0, init_done}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int lat, n0, g;
    logic [7:0] b2b [3];
    logic rr;
    logic [7:0] dd;

    vecs[0] = '{1'b1, 8'h41, 19};
    vecs[1] = '{1'b0, 8'h01, 39};
    vecs[2] = '{1'b0, 8'h80, 19};
    vecs[3] = '{1'b1, 8'h01, 19};
    vecs[4] = '{1'b0, 8'h02, 39};
    vecs[5] = '{1'b0, 8'h03, 39};
    vecs[6] = '{1'b0, 8'h04, 19};
    vecs[7] = '{1'b0, 8'h00, 19};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (100) tick();

    run_init();
    check("init_en_count", en_log.size(), 7);
    for (int i = 0; i < 7 && i < en_log.size(); i++)
      check("init_en_byte", {23'd0, en_log[i]}, {23'd0, 1'b0, rom[i]});

    foreach (vecs[i]) begin
      n0 = en_log.size();
      send(vecs[i].rs, vecs[i].data);
      cmd_valid = 1'b0;
      lat = 1;
      while (!cmd_ready && lat < 300) begin
        tick();
        lat++;
      end
      check("ready_latency", lat, vecs[i].lat);
      check("one_en_pulse", en_log.size(), n0 + 1);
      if (en_log.size() > n0)
        check("pulse_byte", {23'd0, en_log[n0]}, {23'd0, vecs[i].rs, vecs[i].data});
    end

    b2b = '{8'h48, 8'h49, 8'h21};
    n0 = en_log.size();
    for (int i = 0; i < 3; i++) send(1'b1, b2b[i]);
    cmd_valid = 1'b0;
    g = 0;
    while (!cmd_ready && g < 300) begin
      tick();
      g++;
    end
    check("b2b_pulse_count", en_log.size(), n0 + 3);
    for (int i = 0; i < 3 && n0 + i < en_log.size(); i++)
      check("b2b_byte", {23'd0, en_log[n0 + i]}, {23'd0, 1'b1, b2b[i]});

    for (int n = 0; n < 60; n++) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      rr = 1'($urandom_range(0, 1));
      dd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      send(rr, dd);
    end
    cmd_valid = 1'b0;
    repeat (40) tick();

    send(1'b1, 8'h5A);
    cmd_valid = 1'b0;
    g = 0;
    while (!EN && g < 50) begin
      tick();
      g++;
    end
    check("en_high_before_reset", {31'd0, EN}, 32'd1);
    #2;
    do_reset();
    repeat (30) tick();
    run_init();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
